// File: rtl/voice_scheduler_if.sv
// Event handshake between the synth register block (master) and the voice scheduler (slave).
interface voice_scheduler_if #(
    parameter int unsigned NOTEW = 7
);
    logic             ev_valid;
    logic             ev_on;
    logic [NOTEW-1:0] ev_note;
    logic             ev_ready;

    modport master (output ev_valid, ev_on, ev_note, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_note, output ev_ready);
endinterface

// File: rtl/voice_scheduler.sv
// Assigns note-on/note-off events to NVOICES gate/note voice slots with retrigger,
// free-voice-by-age selection and oldest-voice stealing; one event in flight at a time.
module voice_scheduler #(
    parameter int unsigned NVOICES = 4,
    parameter int unsigned NOTEW   = 7,
    parameter int unsigned AGEW    = 8
) (
    input  logic                     sample_clock,
    input  logic                     rst,
    voice_scheduler_if.slave         ev,
    output logic [NVOICES-1:0]       gate,
    output logic [NVOICES*NOTEW-1:0] voice_note,
    output logic                     steal
);
    localparam int unsigned IDXW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

    typedef logic [IDXW-1:0] idx_t;
    localparam idx_t LAST_IDX = idx_t'(NVOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_APPLY, S_GAP} state_t;

    state_t           state, state_next;
    logic             ready_q;
    logic             ev_on_q;
    logic [NOTEW-1:0] ev_note_q;
    idx_t             idx;
    logic             match_found, free_found, old_found;
    idx_t             match_idx, free_idx, old_idx, tgt_idx;
    logic [AGEW-1:0]  age    [NVOICES];
    logic [NOTEW-1:0] note_r [NVOICES];

    logic             accept, apply;
    logic             cur_gate;
    logic [AGEW-1:0]  cur_age;
    logic [NOTEW-1:0] cur_note;
    idx_t             tgt;
    logic             tgt_steal, tgt_gated;

    assign ev.ev_ready = ready_q;

    // Priority: retrigger a held match, else the longest-idle free voice, else steal the oldest.
    always_comb begin
        tgt       = old_idx;
        tgt_steal = 1'b1;
        if (match_found) begin
            tgt       = match_idx;
            tgt_steal = 1'b0;
        end else if (free_found) begin
            tgt       = free_idx;
            tgt_steal = 1'b0;
        end
        tgt_gated = gate[tgt];
        cur_gate  = gate[idx];
        cur_age   = age[idx];
        cur_note  = note_r[idx];
    end

    always_ff @(posedge sample_clock) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        apply      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ev.ev_valid && ready_q) begin
                    accept     = 1'b1;
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (idx == LAST_IDX) state_next = S_APPLY;
            end
            S_APPLY: begin
                apply      = 1'b1;
                state_next = (ev_on_q && tgt_gated) ? S_GAP : S_IDLE;
            end
            S_GAP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sample_clock) begin
        if (rst) begin
            ready_q     <= 1'b1;
            gate        <= '0;
            steal       <= 1'b0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            tgt_idx     <= '0;
            for (int i = 0; i < int'(NVOICES); i++) begin
                age[i]    <= '0;
                note_r[i] <= '0;
            end
        end else begin
            ready_q <= (state_next == S_IDLE);
            steal   <= 1'b0;
            for (int i = 0; i < int'(NVOICES); i++) begin
                if (age[i] != {AGEW{1'b1}}) age[i] <= age[i] + AGEW'(1);
            end

            if (accept) begin
                ev_on_q     <= ev.ev_on;
                ev_note_q   <= ev.ev_note;
                idx         <= '0;
                match_found <= 1'b0;
                free_found  <= 1'b0;
                old_found   <= 1'b0;
                match_idx   <= '0;
                free_idx    <= '0;
                old_idx     <= '0;
            end

            // Compare against the candidate's live age so the running increment cancels out.
            if (state == S_SCAN) begin
                idx <= idx + IDXW'(1);
                if (cur_gate) begin
                    if (!match_found && (cur_note == ev_note_q)) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!old_found || (cur_age > age[old_idx])) begin
                        old_found <= 1'b1;
                        old_idx   <= idx;
                    end
                end else if (!free_found || (cur_age > age[free_idx])) begin
                    free_found <= 1'b1;
                    free_idx   <= idx;
                end
            end

            if (apply) begin
                if (ev_on_q) begin
                    note_r[tgt] <= ev_note_q;
                    age[tgt]    <= '0;
                    gate[tgt]   <= !tgt_gated;
                    steal       <= tgt_steal;
                    tgt_idx     <= tgt;
                end else if (match_found) begin
                    gate[match_idx] <= 1'b0;
                    age[match_idx]  <= '0;
                end
            end

            // Held voice was dropped for one cycle at APPLY so its envelope re-attacks.
            if (state == S_GAP) gate[tgt_idx] <= 1'b1;
        end
    end

    always_comb begin
        voice_note = '0;
        for (int i = 0; i < int'(NVOICES); i++) begin
            voice_note[i*NOTEW +: NOTEW] = note_r[i];
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: a behavioural voice model predicts each event's outcome.
module tb_voice_scheduler;
    localparam int unsigned NV = 4;
    localparam int unsigned NW = 7;

    logic             clk;
    logic             rst;
    logic [NV-1:0]    gate;
    logic [NV*NW-1:0] voice_note;
    logic             steal;

    voice_scheduler_if #(.NOTEW(NW)) evif ();

    voice_scheduler #(.NVOICES(NV), .NOTEW(NW), .AGEW(8)) dut (
        .sample_clock (clk),
        .rst          (rst),
        .ev           (evif.slave),
        .gate         (gate),
        .voice_note   (voice_note),
        .steal        (steal)
    );

    typedef struct {
        logic [NV-1:0]    gate6;
        logic [NV-1:0]    gate_final;
        logic [NV*NW-1:0] notes;
        bit               steal;
        bit               gap;
        int               lat;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [NV-1:0] m_gate;
    logic [NW-1:0] m_note [NV];
    int            m_stamp [NV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_age(input int i, input int now);
        int a;
        a = now - m_stamp[i];
        return (a > 255) ? 255 : a;
    endfunction

    task automatic model_reset();
        m_gate = '0;
        for (int i = 0; i < NV; i++) begin
            m_note[i]  = '0;
            m_stamp[i] = cyc;
        end
    endtask

    // Predicts the outcome of an event accepted on the next rising edge.
    task automatic model_event(input logic on, input logic [NW-1:0] note, output exp_t e);
        int now;
        int match;
        int fr;
        int old;
        int tgt;
        now   = cyc;
        match = -1;
        fr    = -1;
        old   = -1;
        tgt   = 0;
        for (int i = 0; i < NV; i++) begin
            if (m_gate[i]) begin
                if (match < 0 && m_note[i] == note) match = i;
                if (old < 0 || m_age(i, now) > m_age(old, now)) old = i;
            end else if (fr < 0 || m_age(i, now) > m_age(fr, now)) begin
                fr = i;
            end
        end
        e.steal = 1'b0;
        e.gap   = 1'b0;
        e.lat   = 6;
        if (on) begin
            tgt          = (match >= 0) ? match : ((fr >= 0) ? fr : old);
            e.steal      = (match < 0) && (fr < 0);
            e.gap        = m_gate[tgt];
            m_note[tgt]  = note;
            m_gate[tgt]  = 1'b1;
            m_stamp[tgt] = now + 6;
        end else if (match >= 0) begin
            m_gate[match]  = 1'b0;
            m_stamp[match] = now + 6;
        end
        e.gate_final = m_gate;
        e.gate6      = m_gate;
        if (e.gap) begin
            e.gate6[tgt] = 1'b0;
            e.lat        = 7;
        end
        e.notes = '0;
        for (int i = 0; i < NV; i++) e.notes[i*NW +: NW] = m_note[i];
    endtask

    task automatic send_event(input logic on, input logic [NW-1:0] note);
        exp_t          e;
        exp_t          got_e;
        int            n;
        int            steals;
        int            waitc;
        logic [NV-1:0] g6;
        logic [NV*NW-1:0] vn6;
        waitc = 0;
        while (!evif.ev_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_event", evif.ev_ready, 1);
        model_event(on, note, e);
        sb.push_back(e);
        evif.ev_valid = 1'b1;
        evif.ev_on    = on;
        evif.ev_note  = note;
        @(negedge clk);
        evif.ev_valid = 1'b0;
        n      = 1;
        steals = steal ? 1 : 0;
        g6     = '0;
        vn6    = '0;
        while (!evif.ev_ready && n < 20) begin
            @(negedge clk);
            n++;
            if (steal) steals++;
            if (n == 6) begin
                g6  = gate;
                vn6 = voice_note;
            end
        end
        got_e = sb.pop_front();
        check("latency", n, got_e.lat);
        check("gate_apply", g6, got_e.gate6);
        check("note_apply", vn6, got_e.notes);
        check("steal_pulses", steals, got_e.steal ? 1 : 0);
        if (got_e.gap) check("gate_after_gap", gate, got_e.gate_final);
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        evif.ev_valid = 1'b0;
        evif.ev_on    = 1'b0;
        evif.ev_note  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("reset_gate", gate, '0);
        check("reset_notes", voice_note, '0);
        check("reset_steal", steal, 0);
        check("reset_ready", evif.ev_ready, 1);

        // Fill all voices, then steal the oldest.
        send_event(1'b1, 7'd60);
        send_event(1'b1, 7'd62);
        send_event(1'b1, 7'd64);
        send_event(1'b1, 7'd67);
        check("full_gate", gate, 4'b1111);
        send_event(1'b1, 7'd69);
        check("steal_note0", voice_note[6:0], 7'd69);

        // Free-voice choice prefers the voice released longest ago.
        send_event(1'b0, 7'd62);
        repeat (100) @(negedge clk);
        send_event(1'b0, 7'd64);
        check("two_released_gate", gate, 4'b1001);
        send_event(1'b1, 7'd72);
        check("free_pick_note1", voice_note[13:7], 7'd72);
        check("free_pick_gate", gate, 4'b1011);

        // Retrigger a held note, release it, and re-press it with a released same-note voice.
        send_event(1'b1, 7'd60);
        send_event(1'b1, 7'd60);
        check("retrig_note2", voice_note[20:14], 7'd60);
        send_event(1'b0, 7'd60);
        check("release_keeps_note", voice_note[20:14], 7'd60);
        send_event(1'b1, 7'd60);
        send_event(1'b0, 7'd50);

        // Reset in the middle of a scan discards the pending event.
        @(negedge clk);
        evif.ev_valid = 1'b1;
        evif.ev_on    = 1'b1;
        evif.ev_note  = 7'd70;
        @(negedge clk);
        evif.ev_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midreset_gate", gate, '0);
        check("midreset_notes", voice_note, '0);
        check("midreset_steal", steal, 0);
        check("midreset_ready", evif.ev_ready, 1);
        repeat (8) @(negedge clk);
        check("midreset_dropped", gate, '0);

        // Mixed traffic over a small note range to exercise matches, steals and misses.
        for (int k = 0; k < 24; k++) begin
            send_event(($urandom_range(0, 2) != 0), 7'(40 + $urandom_range(0, 5)));
        end
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Allocates incoming note-on/note-off events across NVOICES parallel envelope/amplifier voice chains.
- Drives one gate per voice, plus that voice's note number, which feeds the voice's oscillator pitch lookup.
- Sits between the CPU-facing synth register block and the per-voice envelope instances.
- Handles retrigger, free-voice selection and oldest-voice stealing, processing one event at a time.

Parameters:
- NVOICES, 4, number of voices scheduled (2..16).
- NOTEW, 7, width of a note number.
- AGEW, 8, width of each per-voice saturating age counter.

Ports:
- sample_clock  in  1  single block clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_on  in  1  1 = note-on, 0 = note-off; qualified by ev_valid.
- ev_note  in  NOTEW  note number of the event.
- ev_ready  out  1  scheduler can accept an event this cycle.
- gate  out  NVOICES  per-voice gate to the envelopes; bit i = voice i.
- voice_note  out  NVOICES*NOTEW  voice i note at bits [i*NOTEW +: NOTEW].
- steal  out  1  one-cycle pulse when a held voice is taken for a new note.

Behaviour:
- Reset (synchronous):
  - gate=0, all voice_note=0, steal=0, all ages=0, FSM=IDLE, ev_ready=1.
  - Reset mid-scan drops the pending event.
- Ages:
  - Every cycle, each voice age increments, saturating at 2^AGEW-1.
  - A voice's age clears to 0 when it is assigned (gate rises or retriggers) or released (gate falls by note-off).
  - A voice's age clears on the cycle its assignment or release is applied.
- Handshake:
  - Transfer when ev_valid & ev_ready. ev_ready = 1 only in IDLE.
  - ev_valid while not ready is ignored; the source holds it.
  - ev_on/ev_note are latched on transfer.
- FSM IDLE:
  - On transfer: latch the event, idx=0, clear the candidate registers, go to SCAN.
- FSM SCAN: examines voice idx in ascending order, one voice per cycle, NVOICES cycles.
  - match: first voice with gate=1 and note==latched note.
  - free: gate=0 voice with strictly greatest age (ties keep the lower index).
  - oldest: gate=1 voice with strictly greatest age (ties keep the lower index).
  - After idx=NVOICES-1, go to APPLY.
- FSM APPLY, note-on:
  - Target = match if found, else free, else oldest.
  - steal=1 this cycle only if the target is oldest.
  - Target voice_note <= latched note; age <= 0.
  - Target gate=0 (free voice): gate <= 1; next state IDLE.
  - Target gate=1 (retrigger or steal): gate <= 0; next state GAP.
- FSM APPLY, note-off:
  - If match: gate <= 0, age <= 0.
  - If no match: no output change.
  - Next state IDLE.
- FSM GAP:
  - Target gate <= 1, go to IDLE.
  - This forces a one-cycle low gate so the envelope restarts its attack.
- Latency (event accepted at cycle T, N=NVOICES):
  - Outputs are registered and change at the APPLY edge; visible from T+N+2.
  - GAP case: gate low visible at T+N+2, high at T+N+3.
  - ev_ready high again at T+N+2 (T+N+3 for GAP).
- Boundary conditions:
  - A released voice with the same note (gate=0) is not a match; it competes only as a free candidate.
  - At most one voice changes per event.
  - voice_note is retained after release so the envelope tail keeps its pitch.
  - Only the targeted voice's outputs change; all others hold.

Test Plan (NVOICES=4):
- Reset: rst high 2 cycles, release -> gate=0000, all voice_note=0, steal=0, ev_ready=1.
- Single note-on: note-on 60 accepted at T -> ev_ready=0 T+1..T+5; gate=0001 and voice_note[0]=60 visible T+6; steal never 1.
- Stealing:
  - Note-on 60, 62, 64, 67 (each waiting for ev_ready) -> gate=1111, notes 60/62/64/67.
  - Then note-on 69 -> steal=1 for one cycle; gate[0] low exactly one cycle, then high; voice_note[0]=69; voices 1–3 unchanged.
- Free-voice selection by age:
  - From four held notes: note-off 62, then 100 cycles later note-off 64 -> gate=1001.
  - Then note-on 72 -> voice 1 (released earlier) gets 72, gate=1011, steal=0.
- Retrigger:
  - With 60 held on voice 2, note-on 60 -> gate[2] low one cycle then high; voice_note[2]=60; steal=0; no other voice changes.
- No-match and mid-scan reset:
  - Note-off 50 (not held) -> gate and voice_note unchanged; ev_ready returns at T+6.
  - Separately, rst asserted at T+3 of a note-on -> all outputs 0 next cycle, ev_ready=1, event discarded.
